// File: rtl/prbs_gen_chk.sv
// PRBS7/15/23/31 pattern generator and self-synchronising checker with lock tracking and a saturating bit-error counter.
// Latency: tx_data/tx_valid one clk after gen_en; err_word/err_cnt/locked one clk after an rx_valid word.
// Backpressure: none; the generator advances only on gen_en and the checker consumes only rx_valid words.
//
// Optional build macro: PRBS_INVERT_EN adds input 'invert', which inverts both tx_data and rx_data.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   mode[1:0]           polynomial select: 0=PRBS7, 1=PRBS15, 2=PRBS23, 3=PRBS31
//   gen_en, inject_err  advance the generator one word; flip the MSB of the next generated word
//   tx_data, tx_valid   generated word (first bit in time at MSB) and its strobe
//   rx_data, rx_valid   received word (MSB first in time) and its strobe
//   clr_cnt             synchronous clear of err_cnt (wins over an increment in the same cycle)
//   locked, err_word    checker lock state; last checked word had at least one bit error
//   err_cnt             error bits accumulated while locked, saturating
module prbs_gen_chk #(
    parameter int DATA_W      = 8,
    parameter int ERR_CNT_W   = 16,
    parameter int LOCK_THRESH = 32,
    parameter int LOSS_THRESH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           mode,
    input  logic                 gen_en,
    input  logic                 inject_err,
    output logic [DATA_W-1:0]    tx_data,
    output logic                 tx_valid,
    input  logic [DATA_W-1:0]    rx_data,
    input  logic                 rx_valid,
    input  logic                 clr_cnt,
`ifdef PRBS_INVERT_EN
    input  logic                 invert,
`endif
    output logic                 locked,
    output logic                 err_word,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int CNT_MAX = (LOCK_THRESH > LOSS_THRESH) ? LOCK_THRESH : LOSS_THRESH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int POP_W   = $clog2(DATA_W + 1);
    localparam int SUM_W   = ((ERR_CNT_W > POP_W) ? ERR_CNT_W : POP_W) + 1;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } chk_state_t;

    logic [30:0]          gen_s;
    logic [30:0]          chk_c;
    logic [1:0]           mode_q;
    logic                 mode_ok;     // mode_q holds a sampled value (false until the first clk after reset)
    logic                 inj_pend;
    chk_state_t           state;
    logic [CNT_W-1:0]     thr_cnt;

    logic [1:0]           eff_mode;
    logic                 mode_chg;
    logic [4:0]           tap_n;       // index N-1
    logic [4:0]           tap_t;       // index T-1
    logic [30:0]          mask;
    logic [30:0]          gen_next;
    logic [DATA_W-1:0]    gen_word;
    logic [DATA_W-1:0]    flip_mask;
    logic [DATA_W-1:0]    pol_mask;
    logic [DATA_W-1:0]    rx_eff;
    logic [30:0]          chk_next;
    logic [DATA_W-1:0]    err_bits;
    logic [POP_W-1:0]     err_pop;
    logic                 word_err;
    logic [SUM_W-1:0]     cnt_sum;
    logic [ERR_CNT_W-1:0] cnt_sat;

    // Before the first clk the registered mode is not yet meaningful, so the
    // live input selects the polynomial and no mode change is reported.
    assign eff_mode = mode_ok ? mode_q : mode;
    assign mode_chg = mode_ok && (mode != mode_q);

`ifdef PRBS_INVERT_EN
    assign pol_mask = {DATA_W{invert}};
`else
    assign pol_mask = '0;
`endif
    assign rx_eff = rx_data ^ pol_mask;

    always_comb begin
        tap_n = 5'd6;
        tap_t = 5'd5;
        mask  = 31'h0000_007F;
        case (eff_mode)
            2'd0: begin tap_n = 5'd6;  tap_t = 5'd5;  mask = 31'h0000_007F; end
            2'd1: begin tap_n = 5'd14; tap_t = 5'd13; mask = 31'h0000_7FFF; end
            2'd2: begin tap_n = 5'd22; tap_t = 5'd17; mask = 31'h007F_FFFF; end
            default: begin tap_n = 5'd30; tap_t = 5'd27; mask = 31'h7FFF_FFFF; end
        endcase
    end

    // Generator: DATA_W Fibonacci steps per word; the first bit out lands on the MSB.
    always_comb begin
        logic [30:0] s;
        logic        fb;
        s        = gen_s;
        fb       = 1'b0;
        gen_word = '0;
        for (int i = 0; i < DATA_W; i++) begin
            gen_word[DATA_W-1-i] = s[tap_n];
            fb = s[tap_n] ^ s[tap_t];
            s  = ((s << 1) | {30'd0, fb}) & mask;
        end
        gen_next = s;
    end

    always_comb begin
        flip_mask           = '0;
        flip_mask[DATA_W-1] = inj_pend | inject_err;
    end

    // Checker: the state shifts in received bits rather than predicted ones,
    // which is what makes it resynchronise after N clean bits.
    always_comb begin
        logic [30:0] c;
        logic        b;
        c        = chk_c;
        b        = 1'b0;
        err_bits = '0;
        for (int i = 0; i < DATA_W; i++) begin
            b = rx_eff[DATA_W-1-i];
            err_bits[DATA_W-1-i] = b ^ c[tap_n] ^ c[tap_t];
            c = ((c << 1) | {30'd0, b}) & mask;
        end
        chk_next = c;
    end

    always_comb begin
        err_pop = '0;
        for (int i = 0; i < DATA_W; i++) begin
            err_pop = err_pop + POP_W'(err_bits[i]);
        end
    end

    assign word_err = |err_bits;
    assign cnt_sum  = SUM_W'(err_cnt) + SUM_W'(err_pop);
    assign cnt_sat  = (cnt_sum > SUM_W'({ERR_CNT_W{1'b1}})) ? {ERR_CNT_W{1'b1}}
                                                           : cnt_sum[ERR_CNT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_s    <= '1;
            chk_c    <= '0;
            mode_q   <= 2'd0;
            mode_ok  <= 1'b0;
            inj_pend <= 1'b0;
            state    <= HUNT;
            thr_cnt  <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            locked   <= 1'b0;
            err_word <= 1'b0;
            err_cnt  <= '0;
        end else begin
            mode_ok <= 1'b1;
            mode_q  <= mode;

            if (mode_chg) begin
                // Restart both ends on the new polynomial; the error tally survives.
                gen_s    <= '1;
                tx_valid <= 1'b0;
                inj_pend <= inj_pend | inject_err;
                chk_c    <= '0;
                state    <= HUNT;
                thr_cnt  <= '0;
                locked   <= 1'b0;
                err_word <= 1'b0;
            end else begin
                if (gen_en) begin
                    gen_s    <= gen_next;
                    tx_data  <= gen_word ^ flip_mask ^ pol_mask;
                    tx_valid <= 1'b1;
                    inj_pend <= 1'b0;
                end else begin
                    tx_valid <= 1'b0;
                    inj_pend <= inj_pend | inject_err;
                end

                if (rx_valid) begin
                    chk_c    <= chk_next;
                    err_word <= word_err;
                    case (state)
                        HUNT: begin
                            if (word_err) begin
                                thr_cnt <= '0;
                            end else if (thr_cnt == CNT_W'(LOCK_THRESH - 1)) begin
                                state   <= LOCKED;
                                locked  <= 1'b1;
                                thr_cnt <= '0;
                            end else begin
                                thr_cnt <= thr_cnt + 1'b1;
                            end
                        end
                        default: begin
                            if (!word_err) begin
                                thr_cnt <= '0;
                            end else if (thr_cnt == CNT_W'(LOSS_THRESH - 1)) begin
                                state   <= HUNT;
                                locked  <= 1'b0;
                                thr_cnt <= '0;
                            end else begin
                                thr_cnt <= thr_cnt + 1'b1;
                            end
                        end
                    endcase
                end
            end

            // The word that drops lock is still counted, since state is LOCKED while it is checked.
            if (clr_cnt) begin
                err_cnt <= '0;
            end else if (!mode_chg && rx_valid && (state == LOCKED)) begin
                err_cnt <= cnt_sat;
            end
        end
    end

endmodule

// File: doc/prbs_gen_chk.md
Name: prbs_gen_chk

Overview:
Parametrised PRBS pattern generator and self-synchronising checker for link and board bring-up. It generates DATA_W bits per clock from a runtime-selectable polynomial: PRBS7, PRBS15, PRBS23 or PRBS31. It checks a received word stream against the same polynomial, with lock tracking, single-bit error injection and a saturating bit-error counter. It drives uo_out/uio pins at top level; tx→rx can be looped back externally or in a top-level wrapper.

Parameters:
DATA_W, 8, bits generated/checked per clock (1..32)
ERR_CNT_W, 16, width of saturating error-bit counter
LOCK_THRESH, 32, consecutive error-free rx words needed to declare lock
LOSS_THRESH, 4, consecutive errored rx words needed to drop lock

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
mode  in  2  polynomial: 0=PRBS7, 1=PRBS15, 2=PRBS23, 3=PRBS31
gen_en  in  1  advance generator one word this cycle
inject_err  in  1  pulse; flip MSB of next generated word
tx_data  out  DATA_W  generated word, first bit in time at MSB
tx_valid  out  1  tx_data holds a new word
rx_data  in  DATA_W  received word, MSB first in time
rx_valid  in  1  rx_data valid this cycle
clr_cnt  in  1  synchronous clear of err_cnt
locked  out  1  checker in LOCKED state
err_word  out  1  pulse; last checked word had ≥1 bit error
err_cnt  out  ERR_CNT_W  accumulated error bits while locked, saturating

Behaviour:
- Reset is asynchronous and active-low (rst_n); one clock, clk. Reset values: gen state = all ones in low N bits, tx_data=0, tx_valid=0, checker state=0, FSM=HUNT, locked=0, err_word=0, err_cnt=0, counters=0, registered mode=input mode sampled at first clk.
- Polynomial (N, T): PRBS7 (7,6), PRBS15 (15,14), PRBS23 (23,18), PRBS31 (31,28). Only low N bits of 31-bit state are used.
- Generator bit step: out=s[N-1]; fb=s[N-1]^s[T-1]; s={s[N-2:0],fb}. DATA_W steps unrolled per gen_en cycle.
- tx latency: tx_data/tx_valid are registered one cycle after gen_en. tx_valid=0 with tx_data held when gen_en=0.
- inject_err: latched when asserted; applied to MSB of the next generated word only, then cleared. Generator state is not corrupted.
- Checker bit step: pred=c[N-1]^c[T-1]; e=rx_bit^pred; c={c[N-2:0],rx_bit}. This is self-synchronising: N correct bits after any disturbance give zero errors. One flipped bit yields exactly 3 error bits.
- Checker outputs (err_word, err_cnt, locked) are registered one cycle after the rx_valid word. Nothing changes when rx_valid=0.
- FSM HUNT: count consecutive error-free words; at LOCK_THRESH go to LOCKED, with the counter reset on any errored word.
- FSM LOCKED: count consecutive errored words; at LOSS_THRESH go to HUNT, with the counter reset on any clean word.
- err_cnt adds the popcount of error bits only in LOCKED, including the word that causes the LOCKED→HUNT transition. It saturates at all ones.
- clr_cnt has priority over an increment in the same cycle.
- Mode change (input ≠ registered mode): the next cycle re-seeds the generator, clears checker state, forces HUNT and clears the threshold counters. err_cnt is kept. tx_valid=0 that cycle.
- Mid-operation rst_n assertion immediately returns all outputs to reset values.

Optional Feature:
PRBS_INVERT_EN: when defined, adds input port invert (1 bit). invert=1 XORs tx_data with all ones and XORs rx_data with all ones before checking. This supports inverted-polarity links. When undefined, the port is absent and no inversion logic exists.

Test Plan:
- DATA_W=8, mode=0, reset release, gen_en=1: first tx word 8'hFE. Sequence repeats with period 127 bits. tx_valid rises 1 cycle after gen_en.
- Loopback tx→rx, mode=3: locked=1 within ceil(31/8)+LOCK_THRESH+2 cycles; err_cnt stays 0 over 10000 words.
- Locked loopback, one inject_err pulse: err_cnt increments by exactly 3; err_word pulses for 1–2 words; locked stays 1.
- Locked, rx_data forced 8'hFF: 8 errors/word; locked drops after 4 words; err_cnt=32 (plus at most 8 from the pipeline word), then frozen.
- ERR_CNT_W=4 with continuous errors: err_cnt saturates at 15. clr_cnt together with an error returns err_cnt to 0.
- Mode 0→1 while locked: locked=0 next cycle, re-lock on PRBS15. rst_n pulse mid-stream clears all outputs asynchronously.
